// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store unit sitting between a single-cycle datapath and a
// 32-bit data bus. Byte, half and word accesses take one bus beat; doubles
// take two beats (lower word at a, upper word at a+4). Loads are sign- or
// zero-extended to 64 bits. The processor is held with `stall` until the
// access completes, which is signalled by a one-cycle `done` pulse.
//
// Parameters
//   MAX_WAIT    bus_req cycles without bus_ack before the access aborts
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   mem_read, mem_write       load / store request (store wins if both)
//   size                      00 byte, 01 half, 10 word, 11 double
//   unsigned_ld               1 = zero-extend loads, 0 = sign-extend
//   addr, wdata               byte address (only [31:0] used), store data
//   rdata, done, stall        extended load result, completion, hold
//   misaligned, bus_err       completion status (valid with done)
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be   bus request side
//   bus_ack, bus_rdata        bus response side
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Counter only ever has to hold 0 .. MAX_WAIT-1.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;

  // Request fields captured at accept; the datapath may change them freely
  // while stalled.
  logic [31:0]     a_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [31:0]     wd_hi_q;
  logic [31:0]     lo_q;

  logic            req;
  logic            accept;
  logic            lo_capture;
  logic            unused_addr_hi;

  assign req            = mem_read | mem_write;
  assign accept         = (state == IDLE) && req;
  assign lo_capture     = (state == ACC0) && bus_ack;
  assign unused_addr_hi = ^addr[63:32];

  assign stall = accept || (state == ACC0) || (state == ACC1);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [2:0] off);
    unique case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off[2:0];
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz,
                                         input logic [1:0] off);
    unique case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0]  sz,
                                             input logic [31:0] wd);
    unique case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Extract the addressed lane from one bus word and extend it to 64 bits.
  function automatic logic [63:0] load_extend(input logic [1:0]  sz,
                                              input logic [1:0]  off,
                                              input logic        uns,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    w = word;
    unique case (sz)
      2'b00:   return uns ? {56'd0, b} : {{56{b[7]}}, b};
      2'b01:   return uns ? {48'd0, h} : {{48{h[15]}}, h};
      default: return uns ? {32'd0, w} : {{32{w[31]}}, w};
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Request capture (data only, no reset needed)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= addr[31:0];
      size_q  <= size;
      uns_q   <= unsigned_ld;
      wd_hi_q <= wdata[63:32];
    end
    if (lo_capture) begin
      lo_q <= bus_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs. Bus signals are loaded on the edge
  // that enters ACC0/ACC1 so they are stable for the whole beat, and cleared
  // on the edge that leaves.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      rdata      <= '0;

      unique case (state)
        IDLE: begin
          if (req) begin
            if (is_misaligned(size, addr[2:0])) begin
              state      <= RESP;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= ACC0;
              wait_cnt  <= '0;
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= lane_be(size, addr[1:0]);
              bus_wdata <= lane_wdata(size, wdata[31:0]);
            end
          end
        end

        ACC0: begin
          if (bus_ack) begin
            if (size_q == 2'b11) begin
              // Second beat: doubles are 8-byte aligned, so a+4 is the
              // upper word of the same doubleword.
              state     <= ACC1;
              wait_cnt  <= '0;
              bus_addr  <= {a_q[31:2], 2'b00} + 32'd4;
              bus_be    <= 4'b1111;
              bus_wdata <= wd_hi_q;
            end else begin
              state     <= RESP;
              done      <= 1'b1;
              rdata     <= bus_we ? 64'd0
                                  : load_extend(size_q, a_q[1:0], uns_q, bus_rdata);
              bus_req   <= 1'b0;
              bus_we    <= 1'b0;
              bus_addr  <= '0;
              bus_be    <= '0;
              bus_wdata <= '0;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= RESP;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ACC1: begin
          if (bus_ack || (wait_cnt == WAIT_LAST)) begin
            state     <= RESP;
            done      <= 1'b1;
            bus_err   <= !bus_ack;
            rdata     <= (bus_we || !bus_ack) ? 64'd0 : {bus_rdata, lo_q};
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // Single response cycle; stall is low so the request is not re-taken.
        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
